// File: rtl/conv_window_gen_pkg.sv
// conv_window_gen_pkg: constants and types shared by the 3x3 window generator.
//   TAPS / TAP_MC : tap count and centre-tap index (tap k = row k/3, col k%3)
//   pix_t / win_t : pixel word and 9-tap window at the default 1 x 32-bit width
//   tap_idx()     : (row, col) -> tap index
package conv_window_gen_pkg;
  localparam int TAPS          = 9;
  localparam int TAP_MC        = 4;
  localparam int PIX_DATA_BITS = 32;
  localparam int PIX_CH        = 1;

  typedef logic [PIX_CH*PIX_DATA_BITS-1:0] pix_t;
  typedef pix_t [TAPS-1:0]                  win_t;

  function automatic int tap_idx(input int row, input int col);
    return row * 3 + col;
  endfunction
endpackage

// File: rtl/conv_line_buf.sv
// conv_line_buf: two chained row delays of DEPTH pixels each, sharing one
// advance enable.
//   i_clk  : clock
//   i_en   : advance (shift both delays by one pixel)
//   i_pix  : pixel entering the first delay
//   o_row1 : pixel pushed DEPTH advances ago (one grid row up)
//   o_row2 : pixel pushed 2*DEPTH advances ago (two grid rows up)
// Contents are never reset; stale entries are masked downstream.
module conv_line_buf
  import conv_window_gen_pkg::*;
#(
  parameter int DEPTH = 28,
  parameter int PW    = 32
) (
  input  logic          i_clk,
  input  logic          i_en,
  input  logic [PW-1:0] i_pix,
  output logic [PW-1:0] o_row1,
  output logic [PW-1:0] o_row2
);
  logic [PW-1:0] r_l1 [DEPTH];
  logic [PW-1:0] r_l2 [DEPTH];

  assign o_row1 = r_l1[DEPTH-1];
  assign o_row2 = r_l2[DEPTH-1];

  always_ff @(posedge i_clk) begin
    if (i_en) begin
      r_l1[0] <= i_pix;
      r_l2[0] <= r_l1[DEPTH-1];
      for (int i = 1; i < DEPTH; i++) begin
        r_l1[i] <= r_l1[i-1];
        r_l2[i] <= r_l2[i-1];
      end
    end
  end
endmodule

// File: rtl/conv_window_gen.sv
// conv_window_gen: raster pixel stream -> 3x3 sliding windows with optional
// one-pixel zero border and stride 1/2, single registered output stage.
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_in_data/valid     : input pixel, raster order; o_in_ready accepts it
//   o_out_win           : 9 taps, tap 0 in LSBs; o_out_valid / i_out_ready
//   o_out_row/col       : output coordinate; o_out_last marks final window
module conv_window_gen
  import conv_window_gen_pkg::*;
#(
  parameter int WIDTH     = 28,
  parameter int HEIGHT    = 28,
  parameter int DATA_BITS = 32,
  parameter int CH        = 1,
  parameter int PAD       = 0,
  parameter int STRIDE    = 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [CH*DATA_BITS-1:0]      i_in_data,
  input  logic                         i_in_valid,
  output logic                         o_in_ready,
  output logic [9*CH*DATA_BITS-1:0]    o_out_win,
  output logic                         o_out_valid,
  input  logic                         i_out_ready,
  output logic [$clog2(HEIGHT)-1:0]    o_out_row,
  output logic [$clog2(WIDTH)-1:0]     o_out_col,
  output logic                         o_out_last
);
  localparam int PW     = CH * DATA_BITS;
  localparam int GW     = WIDTH + PAD;
  localparam int GH     = HEIGHT + PAD;
  localparam int RW     = $clog2(GH);
  localparam int CW     = $clog2(GW);
  localparam int ORW    = $clog2(HEIGHT);
  localparam int OCW    = $clog2(WIDTH);
  // Largest emitted coordinate, rounded down to the stride grid.
  localparam int LAST_R = ((HEIGHT - 3 + 2*PAD) / STRIDE) * STRIDE;
  localparam int LAST_C = ((WIDTH  - 3 + 2*PAD) / STRIDE) * STRIDE;

  logic [RW-1:0]                   r_row;
  logic [CW-1:0]                   r_col;
  logic [1:0][2:0][PW-1:0]         r_sr;        // columns c-2, c-1 (rows 0..2)
  logic [TAPS-1:0][PW-1:0]         r_out_win;
  logic                            r_out_valid;
  logic [ORW-1:0]                  r_out_row;
  logic [OCW-1:0]                  r_out_col;
  logic                            r_out_last;

  int                              w_orow, w_ocol;
  logic                            w_virt, w_emit, w_can_adv, w_adv;
  logic [PW-1:0]                   w_pix, w_lb1, w_lb2;
  logic [2:0][PW-1:0]              w_newcol;
  logic [2:0][2:0][PW-1:0]         w_cols;
  logic [TAPS-1:0][PW-1:0]         w_win;

  conv_line_buf #(.DEPTH(GW), .PW(PW)) u_lb (
    .i_clk  (i_clk),
    .i_en   (w_adv),
    .i_pix  (w_pix),
    .o_row1 (w_lb1),
    .o_row2 (w_lb2)
  );

  always_comb begin
    w_orow    = int'(r_row) - 2 + PAD;
    w_ocol    = int'(r_col) - 2 + PAD;
    w_virt    = (PAD != 0) && (int'(r_row) == HEIGHT || int'(r_col) == WIDTH);
    w_emit    = (w_orow >= 0) && (w_ocol >= 0) &&
                ((w_orow % STRIDE) == 0) && ((w_ocol % STRIDE) == 0);
    // One output register: only advance if the produced window has a slot.
    w_can_adv = !r_out_valid || i_out_ready || !w_emit;
    o_in_ready = !i_rst && !w_virt && w_can_adv;
    w_adv     = !i_rst && w_can_adv && (w_virt || i_in_valid);
    w_pix     = w_virt ? '0 : i_in_data;
    w_newcol  = {w_pix, w_lb1, w_lb2};
    w_cols    = {w_newcol, r_sr};
    // Zero any tap outside the real frame; this also hides stale line-buffer
    // rows at frame start and the previous row's tail at column wrap.
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        w_win[tap_idx(i, j)] =
          ((w_orow - PAD + i >= 0) && (w_orow - PAD + i < HEIGHT) &&
           (w_ocol - PAD + j >= 0) && (w_ocol - PAD + j < WIDTH)) ? w_cols[j][i] : '0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_row       <= '0;
      r_col       <= '0;
      r_sr        <= '0;
      r_out_win   <= '0;
      r_out_valid <= 1'b0;
      r_out_row   <= '0;
      r_out_col   <= '0;
      r_out_last  <= 1'b0;
    end else begin
      if (w_adv) begin
        r_sr[0] <= r_sr[1];
        r_sr[1] <= w_newcol;
        if (int'(r_col) == GW - 1) begin
          r_col <= '0;
          r_row <= (int'(r_row) == GH - 1) ? '0 : r_row + RW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end
      end
      if (w_adv && w_emit) begin
        r_out_valid <= 1'b1;
        r_out_win   <= w_win;
        r_out_row   <= w_orow[ORW-1:0];
        r_out_col   <= w_ocol[OCW-1:0];
        r_out_last  <= (w_orow == LAST_R) && (w_ocol == LAST_C);
      end else if (i_out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign o_out_win   = r_out_win;
  assign o_out_valid = r_out_valid;
  assign o_out_row   = r_out_row;
  assign o_out_col   = r_out_col;
  assign o_out_last  = r_out_last;
endmodule

// File: tb/tb_conv_window_gen.sv
// tb_conv_window_gen: three 4x4 instances (PAD0/S1, PAD1/S1, PAD1/S2) driven
// one at a time; a reference model pushes expected windows into a scoreboard
// that a monitor pops as the active instance emits them.
module tb_conv_window_gen;
  import conv_window_gen_pkg::*;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int DB = 32;
  localparam int NW = 9 * DB;

  typedef struct {
    win_t win;
    int   row;
    int   col;
    logic last;
  } exp_t;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst       [3];
  logic [DB-1:0] in_data   [3];
  logic          in_valid  [3];
  logic          in_ready  [3];
  logic [NW-1:0] out_win   [3];
  logic          out_valid [3];
  logic          out_ready [3];
  logic [1:0]    out_row   [3];
  logic [1:0]    out_col   [3];
  logic          out_last  [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    conv_window_gen #(
      .WIDTH(W), .HEIGHT(H), .DATA_BITS(DB), .CH(1),
      .PAD(g > 0 ? 1 : 0), .STRIDE(g == 2 ? 2 : 1)
    ) u_dut (
      .i_clk       (clk),
      .i_rst       (rst[g]),
      .i_in_data   (in_data[g]),
      .i_in_valid  (in_valid[g]),
      .o_in_ready  (in_ready[g]),
      .o_out_win   (out_win[g]),
      .o_out_valid (out_valid[g]),
      .i_out_ready (out_ready[g]),
      .o_out_row   (out_row[g]),
      .o_out_col   (out_col[g]),
      .o_out_last  (out_last[g])
    );
  end

  exp_t q[$];
  exp_t m_e;
  int   total = 0, bad = 0;
  int   cur = 0;
  bit   stall_req = 1'b0;
  int   last_cnt = 0, win_cnt = 0;

  task automatic chk(input string tag, input logic [NW-1:0] got, input logic [NW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DB-1:0] pixv(input int f, input int r, input int c);
    if (r < 0 || r >= H || c < 0 || c >= W) return '0;
    return DB'(f * 100 + 4 * r + c + 1);
  endfunction

  // Reference: standard conv output size, stride-spaced coordinates.
  task automatic push_frame(input int d, input int f);
    int pad, s, oh, ow;
    exp_t e;
    pad = (d > 0) ? 1 : 0;
    s   = (d == 2) ? 2 : 1;
    oh  = (H + 2 * pad - 3) / s + 1;
    ow  = (W + 2 * pad - 3) / s + 1;
    for (int i = 0; i < oh; i++) begin
      for (int j = 0; j < ow; j++) begin
        e.row  = i * s;
        e.col  = j * s;
        for (int k = 0; k < 9; k++)
          e.win[k] = pixv(f, e.row - pad + k / 3, e.col - pad + k % 3);
        e.last = (i == oh - 1) && (j == ow - 1);
        q.push_back(e);
      end
    end
  endtask

  // Presents npix pixels of frame f; counts cycles with in_ready low.
  task automatic run_frame(input int d, input int f, input int npix, input int lat_idx,
                           output int stalls);
    int n;
    stalls = 0;
    for (int p = 0; p < npix; p++) begin
      @(negedge clk);
      in_valid[d] = 1'b1;
      in_data[d]  = pixv(f, p / W, p % W);
      #2;
      n = 0;
      while (!in_ready[d] && n < 100) begin
        stalls++;
        n++;
        @(negedge clk);
        #2;
      end
      if (n >= 100) chk("accept_timeout", 1, 0);
      @(posedge clk);
      #1;
      if (p == lat_idx) chk("latency", out_valid[d], 1);
    end
  endtask

  task automatic drain(input int d);
    int n;
    @(negedge clk);
    in_valid[d] = 1'b0;
    n = 0;
    while (q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("drain_q", q.size(), 0);
    chk("idle_valid", out_valid[d], 0);
  endtask

  // Monitor: optional 5-cycle backpressure on the first window after
  // stall_req, then compare each accepted window against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (out_valid[cur]) begin
        if (stall_req && q.size() != 0) begin
          stall_req = 1'b0;
          out_ready[cur] = 1'b0;
          #1;
          for (int i = 0; i < 5; i++) begin
            chk("stall_in_ready", in_ready[cur], 0);
            @(negedge clk);
            chk("stall_valid", out_valid[cur], 1);
            chk("stall_win", out_win[cur], q[0].win);
            chk("stall_row", out_row[cur], q[0].row);
            chk("stall_col", out_col[cur], q[0].col);
          end
          out_ready[cur] = 1'b1;
        end
        if (q.size() == 0) begin
          chk("sb_extra", 1, 0);
        end else begin
          m_e = q.pop_front();
          chk("win", out_win[cur], m_e.win);
          chk("row", out_row[cur], m_e.row);
          chk("col", out_col[cur], m_e.col);
          chk("last", out_last[cur], m_e.last);
          if (cur == 2 && m_e.row == 2 && m_e.col == 2)
            chk("centre", out_win[cur][TAP_MC*DB +: DB], 11);
        end
        win_cnt++;
        if (out_last[cur]) last_cnt++;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int st, st2, l0, w0;
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1; in_valid[d] = 1'b0; in_data[d] = '0; out_ready[d] = 1'b1;
    end
    repeat (3) @(negedge clk);
    #2;
    for (int d = 0; d < 3; d++) begin
      chk("rst_valid", out_valid[d], 0);
      chk("rst_ready", in_ready[d], 0);
      chk("rst_last", out_last[d], 0);
      chk("rst_row", out_row[d], 0);
      chk("rst_col", out_col[d], 0);
      chk("rst_win", out_win[d], 0);
    end
    @(negedge clk);
    for (int d = 0; d < 3; d++) rst[d] = 1'b0;
    #2;
    for (int d = 0; d < 3; d++) chk("post_rst_ready", in_ready[d], 1);

    // PAD=0 stride 1, single frame; first window right after pixel 11.
    cur = 0;
    push_frame(0, 0);
    run_frame(0, 0, 16, 10, st);
    chk("pad0_stalls", st, 0);
    drain(0);

    // Reset after 7 pixels, then a clean frame.
    run_frame(0, 1, 7, -1, st);
    @(negedge clk);
    in_valid[0] = 1'b0;
    rst[0] = 1'b1;
    #2;
    chk("midrst_ready", in_ready[0], 0);
    @(negedge clk);
    #2;
    chk("midrst_valid", out_valid[0], 0);
    @(negedge clk);
    rst[0] = 1'b0;
    #2;
    chk("midrst_ready_after", in_ready[0], 1);
    push_frame(0, 0);
    run_frame(0, 0, 16, 10, st);
    drain(0);

    // Two frames back to back with backpressure on the first window.
    l0 = last_cnt; w0 = win_cnt;
    stall_req = 1'b1;
    push_frame(0, 3);
    run_frame(0, 3, 16, -1, st);
    push_frame(0, 4);
    run_frame(0, 4, 16, -1, st);
    drain(0);
    chk("b2b_last_pulses", last_cnt - l0, 2);
    chk("b2b_windows", win_cnt - w0, 8);

    // PAD=1 stride 1, two frames back to back; virtual positions stall input.
    cur = 1;
    l0 = last_cnt; w0 = win_cnt;
    push_frame(1, 0);
    run_frame(1, 0, 16, 5, st);
    push_frame(1, 6);
    run_frame(1, 6, 16, -1, st2);
    drain(1);
    chk("pad1_stalls", st + st2, 12);
    chk("pad1_windows", win_cnt - w0, 32);
    chk("pad1_last_pulses", last_cnt - l0, 2);

    // PAD=1 stride 2.
    cur = 2;
    w0 = win_cnt;
    push_frame(2, 0);
    run_frame(2, 0, 16, -1, st);
    drain(2);
    chk("s2_windows", win_cnt - w0, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
